// File: rtl/trace_monitor_if.sv
// Bus bundle between a trace_monitor and whatever drives/reads it.
// The master side drives the probe and control; the slave side is the monitor.
interface trace_monitor_if #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned MAX_CYCLES = 50
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(MAX_CYCLES + 1);

    logic              arm;
    logic [DATA_W-1:0] trig_mask;
    logic [DATA_W-1:0] trig_value;
    logic [DATA_W-1:0] sample_in;
    logic              sample_valid;
    logic [AW-1:0]     rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [1:0]        state;
    logic              done;
    logic              triggered;
    logic              timeout;
    logic [AW:0]       fill_count;
    logic [AW-1:0]     trig_index;
    logic [CW-1:0]     cycle_count;

    modport master (
        output arm, trig_mask, trig_value, sample_in, sample_valid, rd_addr,
        input  rd_data, state, done, triggered, timeout, fill_count, trig_index, cycle_count
    );

    modport slave (
        input  arm, trig_mask, trig_value, sample_in, sample_valid, rd_addr,
        output rd_data, state, done, triggered, timeout, fill_count, trig_index, cycle_count
    );
endinterface

// File: rtl/trace_monitor.sv
// Trace/capture unit: circular sample buffer with masked-compare trigger,
// programmable pre-trigger depth, cycle-count timeout and registered readback.
module trace_monitor #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned PRE_TRIG   = 2,
    parameter int unsigned MAX_CYCLES = 50
) (
    input logic           clock,
    input logic           reset,
    trace_monitor_if.slave bus
);
    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned CW     = $clog2(MAX_CYCLES + 1);
    localparam int unsigned POST_N = DEPTH - PRE_TRIG - 1;
    localparam int unsigned PW     = (POST_N > 0) ? $clog2(POST_N + 1) : 1;
    localparam bit          NO_POST = (POST_N == 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            st;
    logic              done_r;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     trig_ptr;
    logic [AW-1:0]     trig_idx;
    logic [AW:0]       fill;
    logic [CW-1:0]     cyc;
    logic              trig;
    logic              tmo;
    logic [PW-1:0]     post_cnt;
    logic [DATA_W-1:0] rd_q;

    logic              match;
    logic              capturing;
    logic              wr_en;
    logic              trig_hit;
    logic              complete;
    logic              hit_limit;
    logic [AW-1:0]     wr_ptr_nx;
    logic [AW:0]       fill_nx;
    logic [AW-1:0]     trig_ptr_nx;
    logic [AW-1:0]     oldest;
    logic [AW-1:0]     oldest_nx;
    logic [AW-1:0]     rd_idx;

    // Next-cycle pointer view; trig_index must reflect the buffer after the final write.
    always_comb begin
        match       = bus.sample_valid &
                      ((bus.sample_in & bus.trig_mask) == (bus.trig_value & bus.trig_mask));
        capturing   = (st == S_ARMED) || (st == S_POST);
        wr_en       = capturing && bus.sample_valid;
        trig_hit    = (st == S_ARMED) && match;
        wr_ptr_nx   = wr_ptr + AW'(wr_en);
        fill_nx     = (wr_en && (fill != (AW+1)'(DEPTH))) ? fill + (AW+1)'(1) : fill;
        trig_ptr_nx = trig_hit ? wr_ptr : trig_ptr;
        complete    = (trig_hit && NO_POST) ||
                      ((st == S_POST) && bus.sample_valid && (post_cnt == PW'(1)));
        hit_limit   = (cyc == CW'(MAX_CYCLES - 1));
        oldest      = (fill == (AW+1)'(DEPTH)) ? wr_ptr : '0;
        oldest_nx   = (fill_nx == (AW+1)'(DEPTH)) ? wr_ptr_nx : '0;
        rd_idx      = AW'(oldest + bus.rd_addr);
    end

    // Sample storage is never cleared; only live captures write it.
    always_ff @(posedge clock) begin
        if (!reset && wr_en) begin
            mem[wr_ptr] <= bus.sample_in;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            st       <= S_IDLE;
            done_r   <= 1'b0;
            wr_ptr   <= '0;
            trig_ptr <= '0;
            trig_idx <= '0;
            fill     <= '0;
            cyc      <= '0;
            trig     <= 1'b0;
            tmo      <= 1'b0;
            post_cnt <= '0;
            rd_q     <= '0;
        end else begin
            rd_q <= mem[rd_idx];
            case (st)
                S_IDLE, S_DONE: begin
                    if (bus.arm) begin
                        st       <= S_ARMED;
                        done_r   <= 1'b0;
                        wr_ptr   <= '0;
                        fill     <= '0;
                        cyc      <= '0;
                        trig     <= 1'b0;
                        tmo      <= 1'b0;
                        post_cnt <= '0;
                    end
                end
                S_ARMED, S_POST: begin
                    wr_ptr <= wr_ptr_nx;
                    fill   <= fill_nx;
                    cyc    <= cyc + CW'(1);
                    if (trig_hit) begin
                        trig     <= 1'b1;
                        trig_ptr <= wr_ptr;
                        post_cnt <= PW'(POST_N);
                    end else if ((st == S_POST) && bus.sample_valid) begin
                        post_cnt <= post_cnt - PW'(1);
                    end
                    // Completion outranks the timeout when both land on the same cycle.
                    if (complete || hit_limit) begin
                        st       <= S_DONE;
                        done_r   <= 1'b1;
                        tmo      <= !complete;
                        trig_idx <= (trig || trig_hit) ? AW'(trig_ptr_nx - oldest_nx) : '0;
                    end else if (trig_hit) begin
                        st <= S_POST;
                    end
                end
                default: st <= S_IDLE;
            endcase
        end
    end

    assign bus.rd_data     = rd_q;
    assign bus.state       = st;
    assign bus.done        = done_r;
    assign bus.triggered   = trig;
    assign bus.timeout     = tmo;
    assign bus.fill_count  = fill;
    assign bus.trig_index  = trig_idx;
    assign bus.cycle_count = cyc;
endmodule

// File: tb/tb_trace_monitor.sv
// Bench for trace_monitor: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a queue-based model.
module tb_trace_monitor;
    localparam int unsigned DATA_W     = 16;
    localparam int unsigned DEPTH      = 8;
    localparam int unsigned PRE_TRIG   = 2;
    localparam int unsigned MAX_CYCLES = 50;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    trace_monitor_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_CYCLES(MAX_CYCLES)) bus ();

    trace_monitor #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .PRE_TRIG(PRE_TRIG), .MAX_CYCLES(MAX_CYCLES)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the capture is the list of stored samples, newest last, capped at DEPTH.
    int          m_state = 0;
    logic [15:0] m_q[$];
    bit          m_trig, m_to, m_live, m_rd_ok;
    int          m_cyc, m_post_left, m_post_writes, m_tidx, m_next;
    logic [15:0] m_rd;
    bit          m_hit, m_fin;

    always @(posedge clock) begin
        if (reset) begin
            m_state = 0; m_q.delete(); m_trig = 0; m_to = 0; m_cyc = 0;
            m_rd = 16'h0000; m_rd_ok = 1; m_tidx = 0; m_live = 1;
        end else begin
            m_rd_ok = int'(bus.rd_addr) < m_q.size();
            if (m_rd_ok) m_rd = m_q[bus.rd_addr];
            if (m_state == 0 || m_state == 3) begin
                if (bus.arm) begin
                    m_state = 1; m_q.delete(); m_cyc = 0; m_trig = 0; m_to = 0;
                end
            end else begin
                m_hit  = bus.sample_valid &&
                         ((bus.sample_in & bus.trig_mask) == (bus.trig_value & bus.trig_mask));
                m_next = m_state;
                m_fin  = 0;
                if (bus.sample_valid) begin
                    m_q.push_back(bus.sample_in);
                    if (m_q.size() > DEPTH) void'(m_q.pop_front());
                end
                if (m_state == 1 && m_hit) begin
                    m_trig = 1; m_post_writes = 0;
                    m_post_left = DEPTH - PRE_TRIG - 1;
                    if (m_post_left == 0) m_fin = 1; else m_next = 2;
                end else if (m_state == 2 && bus.sample_valid) begin
                    m_post_writes++; m_post_left--;
                    if (m_post_left == 0) m_fin = 1;
                end
                if (m_fin) m_next = 3;
                else if (m_cyc == MAX_CYCLES - 1) begin m_next = 3; m_to = 1; end
                m_cyc++;
                if (m_next == 3) m_tidx = m_trig ? m_q.size() - 1 - m_post_writes : 0;
                m_state = m_next;
            end
        end
    end

    always @(negedge clock) begin
        if (m_live) begin
            chk("state", 32'(bus.state), 32'(m_state));
            chk("done", 32'(bus.done), 32'(m_state == 3));
            chk("triggered", 32'(bus.triggered), 32'(m_trig));
            chk("timeout", 32'(bus.timeout), 32'(m_to));
            chk("fill_count", 32'(bus.fill_count), 32'(m_q.size()));
            chk("cycle_count", 32'(bus.cycle_count), 32'(m_cyc));
            if (m_rd_ok) chk("rd_data", 32'(bus.rd_data), 32'(m_rd));
            if (m_state == 0 || m_state == 3) chk("trig_index", 32'(bus.trig_index), 32'(m_tidx));
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic do_arm(input logic [15:0] mask, input logic [15:0] val);
        bus.trig_mask = mask; bus.trig_value = val;
        bus.arm = 1'b1; cyc(); bus.arm = 1'b0;
    endtask

    task automatic stream(input int first, input int count);
        for (int i = 0; i < count; i++) begin
            bus.sample_in = 16'(first + i); bus.sample_valid = 1'b1; cyc();
        end
        bus.sample_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!bus.done && n < 200) begin cyc(); n++; end
        chk(name, 32'(bus.done), 32'd1);
    endtask

    task automatic rd_chk(input int addr, input int exp, input string name);
        bus.rd_addr = 3'(addr); cyc();
        chk(name, 32'(bus.rd_data), 32'(exp));
    endtask

    task automatic scenario_basic(input string tag);
        stream(1, 16);
        wait_done({tag, "_done"});
        chk({tag, "_fill"}, 32'(bus.fill_count), 32'd8);
        chk({tag, "_tidx"}, 32'(bus.trig_index), 32'd2);
        chk({tag, "_tmo"}, 32'(bus.timeout), 32'd0);
        for (int i = 0; i < 8; i++) rd_chk(i, 3 + i, {tag, "_rd"});
    endtask

    logic [15:0] samp_log[$];
    logic [15:0] x;

    initial begin
        bus.arm = 0; bus.trig_mask = '0; bus.trig_value = '0;
        bus.sample_in = '0; bus.sample_valid = 0; bus.rd_addr = '0;

        reset = 1; cyc(); cyc();
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_rd_data", 32'(bus.rd_data), 32'h0000);
        chk("rst_fill", 32'(bus.fill_count), 32'd0);
        chk("rst_cycles", 32'(bus.cycle_count), 32'd0);
        reset = 0; cyc();

        do_arm(16'hFFFF, 16'h0005);
        scenario_basic("basic");

        do_arm(16'hFFFF, 16'h0005);
        stream(5, 11);
        wait_done("early_done");
        chk("early_fill", 32'(bus.fill_count), 32'd6);
        chk("early_tidx", 32'(bus.trig_index), 32'd0);
        for (int i = 0; i < 6; i++) rd_chk(i, 5 + i, "early_rd");

        do_arm(16'hFFFF, 16'hFFFF);
        samp_log.delete();
        for (int n = 0; n < 200; n++) begin
            x = 16'($urandom_range(0, 16'hFFFE));
            samp_log.push_back(x);
            bus.sample_in = x; bus.sample_valid = 1'b1; cyc();
            if (bus.done) break;
        end
        bus.sample_valid = 1'b0;
        chk("tmo_done", 32'(bus.done), 32'd1);
        chk("tmo_timeout", 32'(bus.timeout), 32'd1);
        chk("tmo_trig", 32'(bus.triggered), 32'd0);
        chk("tmo_fill", 32'(bus.fill_count), 32'd8);
        if (samp_log.size() >= 8) rd_chk(0, int'(samp_log[samp_log.size() - 8]), "tmo_oldest");
        else chk("tmo_len", 32'(samp_log.size()), 32'd8);

        do_arm(16'hFF00, 16'h1200);
        bus.sample_in = 16'h13AB; bus.sample_valid = 1; cyc();
        bus.sample_in = 16'h12AB; bus.sample_valid = 0; cyc();
        chk("mask_no_trig", 32'(bus.triggered), 32'd0);
        chk("mask_no_write", 32'(bus.fill_count), 32'd1);
        bus.sample_valid = 1; cyc(); bus.sample_valid = 0;
        chk("mask_trig", 32'(bus.triggered), 32'd1);
        chk("mask_fill", 32'(bus.fill_count), 32'd2);
        chk("mask_post", 32'(bus.state), 32'd2);
        stream(16'h20, 10);
        wait_done("mask_done");

        do_arm(16'hFFFF, 16'h0005);
        stream(5, 4);
        reset = 1; cyc();
        chk("midrst_state", 32'(bus.state), 32'd0);
        chk("midrst_fill", 32'(bus.fill_count), 32'd0);
        reset = 0; cyc();
        do_arm(16'hFFFF, 16'h0005);
        stream(1, 16);
        wait_done("rearm_first_done");
        do_arm(16'hFFFF, 16'h0005);
        chk("rearm_fill", 32'(bus.fill_count), 32'd0);
        chk("rearm_trig", 32'(bus.triggered), 32'd0);
        chk("rearm_state", 32'(bus.state), 32'd1);
        scenario_basic("rearm");

        // Random traffic; small compare fields so both triggers and timeouts occur.
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 199) == 0);
            bus.arm = ($urandom_range(0, 11) == 0);
            if (bus.arm) begin
                bus.trig_mask  = ($urandom_range(0, 1) == 0) ? 16'h000F : 16'h0003;
                bus.trig_value = 16'($urandom_range(0, 16'hFFFF));
            end
            bus.sample_in    = 16'($urandom_range(0, 15)) | 16'($urandom_range(0, 15) << 8);
            bus.sample_valid = ($urandom_range(0, 3) != 0);
            bus.rd_addr      = 3'($urandom_range(0, 7));
            cyc();
        end
        reset = 0; bus.arm = 0; bus.sample_valid = 0;
        cyc(); cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/trace_monitor.md
Name: trace_monitor

Overview:
Parametrised on-chip trace/capture unit for the 16-bit processor. It samples one observed bus (data bus, address bus or a control-word slice) into a circular buffer and triggers on a masked compare. It keeps a programmable number of pre-trigger samples and stops either on buffer completion or on a cycle-count timeout. It replaces fixed-duration "run N ns then stop" simulation with synthesizable, readable-back capture.

Parameters:
DATA_W, 16, width of sampled bus and compare value
DEPTH, 8, buffer entries; power of 2, at least 4
PRE_TRIG, 2, pre-trigger entries kept; 0 to DEPTH-1
MAX_CYCLES, 50, armed-cycle limit before timeout; at least 1
(derived) AW = clog2(DEPTH); CW = clog2(MAX_CYCLES+1)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
arm  in  1  start a capture (pulse)
trig_mask  in  DATA_W  compare mask; 1 = bit compared
trig_value  in  DATA_W  compare value
sample_in  in  DATA_W  observed bus
sample_valid  in  1  sample_in is valid this cycle
rd_addr  in  AW  read index; 0 = oldest stored sample
rd_data  out  DATA_W  registered read data
state  out  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE
done  out  1  capture finished (state==DONE)
triggered  out  1  trigger occurred in this capture
timeout  out  1  capture ended by MAX_CYCLES
fill_count  out  AW+1  stored samples, saturates at DEPTH
trig_index  out  AW  read index of the trigger sample
cycle_count  out  CW  cycles spent in ARMED+POST

Behaviour:
- Reset (sync, active-high; takes priority over every other input): state=IDLE. rd_data, fill_count, trig_index, cycle_count, triggered and timeout are all 0. Write pointer is 0. Buffer RAM is not cleared.
- match = sample_valid & ((sample_in & trig_mask) == (trig_value & trig_mask)).
- IDLE: arm=1 -> ARMED; clear wr_ptr, fill_count, cycle_count, triggered, timeout and the post counter. Other inputs are ignored.
- ARMED:
  - sample_valid writes sample_in at wr_ptr; wr_ptr increments modulo DEPTH; fill_count increments and saturates at DEPTH.
  - match: the matching sample is written; triggered=1; trig_ptr=wr_ptr; the post counter loads DEPTH-PRE_TRIG-1; state goes to POST.
  - If DEPTH-PRE_TRIG-1 == 0, go directly to DONE.
- POST: each valid sample is written and decrements the post counter. The write that takes the counter to 0 moves state to DONE. Further matches are ignored.
- Post-trigger samples kept, trigger sample included, = DEPTH-PRE_TRIG.
- Early trigger: if fewer than PRE_TRIG samples precede the trigger, fewer pre-samples are kept. The post count is unchanged.
- cycle_count increments every cycle in ARMED or POST.
- Timeout: if cycle_count reaches MAX_CYCLES-1 and this cycle does not complete the capture, go to DONE with timeout=1. The sample in that cycle is still written.
- Completion and timeout in the same cycle: completion wins; timeout stays 0.
- DONE:
  - No writes.
  - arm=1 restarts, exactly as arm from IDLE.
  - arm in ARMED or POST is ignored.
- Readout:
  - oldest = wr_ptr if fill_count==DEPTH, else 0.
  - rd_data <= buf[(oldest+rd_addr) mod DEPTH], registered, 1-cycle latency, valid in any state.
  - trig_index = (trig_ptr - oldest) mod DEPTH, updated on entry to DONE; 0 if triggered=0.
  - Reads with rd_addr >= fill_count return stale data.
- Reset mid-capture: return to IDLE immediately with all outputs at reset values.

Test Plan:
1. reset high 2 cycles, then low -> state=0, done=0, rd_data=0x0000, fill_count=0, cycle_count=0.
2. mask 0xFFFF, value 0x0005, arm, then samples 0x0001..0x0010 one per cycle -> trigger on 0x0005, done after 0x000A is written. fill_count=8, rd_addr 0..7 return 0x0003..0x000A, trig_index=2, timeout=0.
3. Early trigger: value 0x0005, samples 0x0005..0x000F -> done after 0x000A. fill_count=6, rd_addr 0..5 return 0x0005..0x000A, trig_index=0.
4. Timeout: value 0xFFFF, samples never match, valid every cycle -> done at cycle_count=49. timeout=1, triggered=0, fill_count=8, rd_addr 0 returns the oldest of the last 8 samples.
5. Mask: mask 0xFF00, value 0x1200, sample 0x12AB -> triggered=1. Sample 0x13AB does not trigger. With sample_valid=0 and sample_in=0x12AB -> no trigger, no write.
6. Assert reset 3 cycles into POST -> state=0 the next cycle. Re-arm a finished capture from DONE -> fill_count=0, triggered=0, and a new capture proceeds as in scenario 2.
